// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer and status controller for the asynchronous FIFO (wclk domain).
// Full is computed from the next pointer, so it is exact on the cycle the last slot fills.
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  wclr_ovf,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  wovf
);

    localparam logic [ADDR_WIDTH:0] AFULL_TH = AFULL_LEVEL[ADDR_WIDTH:0];

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDR_WIDTH:0] wbin_r;
    logic [ADDR_WIDTH:0] wptr_r;
    logic                wfull_r;
    logic                walmost_full_r;
    logic [ADDR_WIDTH:0] wcount_r;
    logic                wovf_r;

    logic                wen_s;
    logic [ADDR_WIDTH:0] rbin_s;
    logic [ADDR_WIDTH:0] wbin_next_s;
    logic [ADDR_WIDTH:0] wgray_next_s;
    logic [ADDR_WIDTH:0] wcount_next_s;
    logic [ADDR_WIDTH:0] full_cmp_s;
    logic                wfull_next_s;
    logic                wafull_next_s;
    logic                wovf_next_s;

    // Next-state logic for pointer, fill level and status flags
    always_comb begin
        wen_s         = winc & ~wfull_r;
        rbin_s        = gray2bin(wq2_rptr);
        wbin_next_s   = wbin_r + {{ADDR_WIDTH{1'b0}}, wen_s};
        wgray_next_s  = bin2gray(wbin_next_s);
        wcount_next_s = wbin_next_s - rbin_s;
        // Full when the next write pointer sits one lap ahead of the read pointer
        full_cmp_s    = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
        wfull_next_s  = (wgray_next_s == full_cmp_s);
        wafull_next_s = (wcount_next_s >= AFULL_TH);
        // Set beats clear so an overflow in the clearing cycle is not lost
        if (winc & wfull_r) begin
            wovf_next_s = 1'b1;
        end else if (wclr_ovf) begin
            wovf_next_s = 1'b0;
        end else begin
            wovf_next_s = wovf_r;
        end
    end

    // State and status registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_r         <= {(ADDR_WIDTH+1){1'b0}};
            wptr_r         <= {(ADDR_WIDTH+1){1'b0}};
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wcount_r       <= {(ADDR_WIDTH+1){1'b0}};
            wovf_r         <= 1'b0;
        end else begin
            wbin_r         <= wbin_next_s;
            wptr_r         <= wgray_next_s;
            wfull_r        <= wfull_next_s;
            walmost_full_r <= wafull_next_s;
            wcount_r       <= wcount_next_s;
            wovf_r         <= wovf_next_s;
        end
    end

    assign wen          = wen_s;
    assign waddr        = wbin_r[ADDR_WIDTH-1:0];
    assign wptr         = wptr_r;
    assign wfull        = wfull_r;
    assign walmost_full = walmost_full_r;
    assign wcount       = wcount_r;
    assign wovf         = wovf_r;

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Directed self-checking bench for fifo_wptr_full_ctrl (ADDR_WIDTH=4, AFULL_LEVEL=12).
module tb_fifo_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wclr_ovf;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wcount;
    logic       wovf;

    int total = 0;
    int bad   = 0;

    fifo_wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_LEVEL(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wclr_ovf(wclr_ovf), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount), .wovf(wovf)
    );

    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_waddr"}, 32'(waddr), 32'd0);
        check_eq({tag, "_wptr"}, 32'(wptr), 32'd0);
        check_eq({tag, "_wfull"}, 32'(wfull), 32'd0);
        check_eq({tag, "_wafull"}, 32'(walmost_full), 32'd0);
        check_eq({tag, "_wcount"}, 32'(wcount), 32'd0);
        check_eq({tag, "_wovf"}, 32'(wovf), 32'd0);
    endtask

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wq2_rptr = 5'd0;
        wclr_ovf = 1'b0;
        #3;
        check_all_zero("rst");
        check_eq("rst_wen", 32'(wen), 32'd1);
        tick();
        check_all_zero("rst_edge");
        check_eq("rst_edge_wen", 32'(wen), 32'd1);

        // Release with no writes
        winc = 1'b0;
        #2;
        wrst_n = 1'b1;
        tick();
        check_all_zero("idle");
        check_eq("idle_wen", 32'(wen), 32'd0);

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            winc = 1'b1;
            tick();
            check_eq("fill_wcount", 32'(wcount), 32'(i));
            check_eq("fill_wafull", 32'(walmost_full), (i >= 12) ? 32'd1 : 32'd0);
            check_eq("fill_wfull", 32'(wfull), (i == 16) ? 32'd1 : 32'd0);
            check_eq("fill_waddr", 32'(waddr), 32'(i % 16));
        end
        check_eq("full_wptr", 32'(wptr), 32'b11000);
        check_eq("full_wen_blocked", 32'(wen), 32'd0);
        winc = 1'b0;
        #1;
        check_eq("full_wovf_pre", 32'(wovf), 32'd0);

        // Overflow pulse
        winc = 1'b1;
        #1;
        check_eq("ovf_wen", 32'(wen), 32'd0);
        tick();
        winc = 1'b0;
        check_eq("ovf_wovf", 32'(wovf), 32'd1);
        check_eq("ovf_wptr", 32'(wptr), 32'b11000);
        check_eq("ovf_waddr", 32'(waddr), 32'd0);
        check_eq("ovf_wcount", 32'(wcount), 32'd16);
        check_eq("ovf_wfull", 32'(wfull), 32'd1);
        tick();
        check_eq("ovf_hold", 32'(wovf), 32'd1);
        wclr_ovf = 1'b1;
        winc     = 1'b1;
        tick();
        check_eq("ovf_set_wins", 32'(wovf), 32'd1);
        winc = 1'b0;
        tick();
        check_eq("ovf_clear", 32'(wovf), 32'd0);
        wclr_ovf = 1'b0;

        // Drain: read side catches up to 16
        wq2_rptr = 5'b11000;
        tick();
        check_eq("drain_wfull", 32'(wfull), 32'd0);
        check_eq("drain_wcount", 32'(wcount), 32'd0);
        check_eq("drain_wafull", 32'(walmost_full), 32'd0);

        // Refill across the wbin wrap
        for (int i = 1; i <= 16; i++) begin
            winc = 1'b1;
            tick();
            check_eq("wrap_wcount", 32'(wcount), 32'(i));
            check_eq("wrap_wfull", 32'(wfull), (i == 16) ? 32'd1 : 32'd0);
        end
        winc = 1'b0;
        check_eq("wrap_wptr", 32'(wptr), 32'b00000);
        check_eq("wrap_waddr", 32'(waddr), 32'd0);

        // Read advance to 17 (Gray 11001) -> fill 15
        wq2_rptr = 5'b11001;
        tick();
        check_eq("rd1_wcount", 32'(wcount), 32'd15);
        check_eq("rd1_wfull", 32'(wfull), 32'd0);
        // Write and read advance (to 18, Gray 11011) in the same cycle
        winc     = 1'b1;
        wq2_rptr = 5'b11011;
        tick();
        winc = 1'b0;
        check_eq("simul_wcount", 32'(wcount), 32'd15);
        check_eq("simul_wfull", 32'(wfull), 32'd0);
        check_eq("simul_wafull", 32'(walmost_full), 32'd1);
        check_eq("simul_wptr", 32'(wptr), 32'b00001);

        // Fresh start, then reset in the middle of a burst
        wrst_n   = 1'b0;
        wq2_rptr = 5'd0;
        #2;
        wrst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            winc = 1'b1;
            tick();
        end
        check_eq("burst_wcount", 32'(wcount), 32'd9);
        check_eq("burst_waddr", 32'(waddr), 32'd9);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check_eq("midrst_wen", 32'(wen), 32'd1);
        #2;
        wrst_n = 1'b1;
        check_eq("post_rst_waddr", 32'(waddr), 32'd0);
        tick();
        winc = 1'b0;
        check_eq("post_rst_waddr1", 32'(waddr), 32'd1);
        check_eq("post_rst_wcount", 32'(wcount), 32'd1);
        check_eq("post_rst_wptr", 32'(wptr), 32'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
